// File: rtl/psum_drain_if.sv
// Output beat stream of the partial-sum drain: one requantized lane per beat.
interface psum_drain_if #(
  parameter int OW = 8,
  parameter int LW = 3
);
  logic                 m_valid;
  logic                 m_ready;
  logic signed [OW-1:0] m_data;
  logic [LW-1:0]        m_lane;
  logic                 m_last;
  logic                 sat;

  modport master (
    output m_valid, m_data, m_lane, m_last, sat,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_lane, m_last, sat,
    output m_ready
  );
endinterface

// File: rtl/psum_drain.sv
// Partial-sum drain: captures a LANES x DW accumulator vector on load, then
// streams it out one requantized lane per beat (ReLU, rounding shift,
// signed saturation to OW bits) and pulses acc_clr to restart accumulation.
module psum_drain #(
  parameter int LANES = 7,
  parameter int DW    = 32,
  parameter int OW    = 8,
  parameter int LW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [LANES*DW-1:0]   din_i,
  input  logic [4:0]            shift_i,
  input  logic                  relu_en_i,
  output logic                  ready_in_o,
  output logic                  acc_clr_o,
  output logic                  overrun_o,
  psum_drain_if.master          m
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  // Saturation bounds and rounding unit, all in the widened DW+1 domain.
  localparam logic signed [DW:0] MAXV = {{(DW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [DW:0] MINV = {{(DW-OW+2){1'b1}}, {(OW-1){1'b0}}};
  localparam logic signed [DW:0] ONE  = {{DW{1'b0}}, 1'b1};

  // Returns {sat, y}. The rounding add is done one bit wider than the lane so
  // a near-max positive value plus the half-LSB cannot wrap negative.
  function automatic logic [OW:0] requant(input logic signed [DW-1:0] x,
                                          input logic [4:0]           sh,
                                          input logic                 relu);
    logic signed [DW:0]   rnd;
    logic signed [DW:0]   s;
    logic signed [DW:0]   r;
    logic signed [OW-1:0] y;
    logic                 sat;
    rnd = '0;
    s   = '0;
    r   = '0;
    y   = '0;
    sat = 1'b0;
    if (relu && x[DW-1]) begin
      y   = '0;
      sat = 1'b0;
    end else begin
      if (sh != 5'd0) rnd = ONE <<< (sh - 5'd1);
      s = $signed({x[DW-1], x}) + rnd;
      r = s >>> sh;
      if (r > MAXV) begin
        y   = MAXV[OW-1:0];
        sat = 1'b1;
      end else if (r < MINV) begin
        y   = MINV[OW-1:0];
        sat = 1'b1;
      end else begin
        y   = r[OW-1:0];
        sat = 1'b0;
      end
    end
    return {sat, y};
  endfunction

  logic [0:0]           state_q, state_d;
  logic [LANES*DW-1:0]  cap_q, cap_d;
  logic [4:0]           shift_q, shift_d;
  logic                 relu_q, relu_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic                 last_q, last_d;
  logic signed [OW-1:0] data_q, data_d;
  logic                 sat_q, sat_d;
  logic                 acc_clr_q, acc_clr_d;
  logic                 overrun_q, overrun_d;

  logic                 valid;
  logic                 hs;
  logic                 ready_in;
  logic                 accept;
  logic [LW-1:0]        lane_inc;
  logic signed [DW-1:0] req_x;
  logic [4:0]           req_sh;
  logic                 req_relu;
  logic [OW:0]          req_res;

  assign valid    = (state_q == DRAIN);
  assign hs       = valid & m.m_ready;
  assign ready_in = (state_q == IDLE) | (valid & hs & last_q);
  assign accept   = load_i & ready_in;
  // Wraps at the last lane so the capture-register select never leaves range.
  assign lane_inc = (lane_q == LAST_LANE) ? '0 : lane_q + LW'(1);

  // Next-state: capture on an accepted load, advance a lane per handshake,
  // and requantize whichever lane becomes the presented beat.
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    lane_d    = lane_q;
    last_d    = last_q;
    data_d    = data_q;
    sat_d     = sat_q;
    acc_clr_d = accept;
    overrun_d = overrun_q | (load_i & ~ready_in);
    req_x     = cap_q[lane_inc*DW +: DW];
    req_sh    = shift_q;
    req_relu  = relu_q;

    if (accept) begin
      // New vector bypasses the capture register for its first beat.
      cap_d    = din_i;
      shift_d  = shift_i;
      relu_d   = relu_en_i;
      state_d  = DRAIN;
      lane_d   = '0;
      req_x    = din_i[DW-1:0];
      req_sh   = shift_i;
      req_relu = relu_en_i;
    end else if (hs) begin
      if (last_q) begin
        state_d = IDLE;
        lane_d  = '0;
      end else begin
        lane_d = lane_inc;
      end
    end

    req_res = requant(req_x, req_sh, req_relu);

    if (accept || (hs && !last_q)) begin
      sat_d  = req_res[OW];
      data_d = req_res[OW-1:0];
      last_d = (lane_d == LAST_LANE);
    end else if (hs && last_q) begin
      last_d = 1'b0;
    end
  end

  // State, capture and output registers; reset abandons any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      lane_q    <= '0;
      last_q    <= 1'b0;
      data_q    <= '0;
      sat_q     <= 1'b0;
      acc_clr_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      lane_q    <= lane_d;
      last_q    <= last_d;
      data_q    <= data_d;
      sat_q     <= sat_d;
      acc_clr_q <= acc_clr_d;
      overrun_q <= overrun_d;
    end
  end

  assign ready_in_o = ready_in;
  assign acc_clr_o  = acc_clr_q;
  assign overrun_o  = overrun_q;
  assign m.m_valid  = valid;
  assign m.m_data   = data_q;
  assign m.m_lane   = lane_q;
  assign m.m_last   = last_q;
  assign m.sat      = sat_q;

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: directed vectors with hand-computed beats pushed to a
// scoreboard; a negedge monitor pops and compares each handshaked beat.
module tb_psum_drain;
  localparam int LANES = 7;
  localparam int DW    = 32;
  localparam int OW    = 8;
  localparam int LW    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                load;
  logic [LANES*DW-1:0] din;
  logic [4:0]          shift;
  logic                relu_en;
  logic                ready_in;
  logic                acc_clr;
  logic                overrun;

  psum_drain_if #(.OW(OW), .LW(LW)) mif ();

  psum_drain #(.LANES(LANES), .DW(DW), .OW(OW), .LW(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .din_i      (din),
    .shift_i    (shift),
    .relu_en_i  (relu_en),
    .ready_in_o (ready_in),
    .acc_clr_o  (acc_clr),
    .overrun_o  (overrun),
    .m          (mif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [7:0] d;
    logic [2:0]        lane;
    logic              last;
    logic              sat;
  } beat_t;

  beat_t sb[$];
  int    tests   = 0;
  int    fails   = 0;
  int    beats   = 0;
  int    acc_cnt = 0;
  int    loads   = 0;

  int    vin[7];
  int    ed[7];
  bit    es[7];

  // monitor-private state
  bit    stalled = 1'b0;
  beat_t held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: beats transfer at the posedge after this negedge.
  always @(negedge clk) begin
    beat_t got, exp;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      got = '{d: mif.m_data, lane: mif.m_lane, last: mif.m_last, sat: mif.sat};
      if (acc_clr) acc_cnt++;
      if (stalled) begin
        tests++;
        if (!mif.m_valid || got !== held) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b d=%0d lane=%0d last=%0b sat=%0b expected v=1 d=%0d lane=%0d last=%0b sat=%0b",
                   mif.m_valid, got.d, got.lane, got.last, got.sat, held.d, held.lane, held.last, held.sat);
        end
      end
      if (mif.m_valid && mif.m_ready) begin
        beats++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected: got d=%0d lane=%0d expected no beat", got.d, got.lane);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL beat: got d=%0d lane=%0d last=%0b sat=%0b expected d=%0d lane=%0d last=%0b sat=%0b",
                     got.d, got.lane, got.last, got.sat, exp.d, exp.lane, exp.last, exp.sat);
          end
        end
      end
      stalled = mif.m_valid && !mif.m_ready;
      held    = got;
    end
  end

  // Push expected beats, wait for ready_in, then issue one load pulse.
  task automatic load_vec(input logic [4:0] sh, input logic relu);
    for (int i = 0; i < LANES; i++)
      sb.push_back('{d: ed[i][7:0], lane: 3'(i), last: (i == LANES-1), sat: es[i]});
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready_in) break;
    end
    if (!ready_in) chk("load_wait_timeout", 32'(ready_in), 32'd1);
    for (int i = 0; i < LANES; i++) din[i*DW +: DW] = vin[i];
    shift   = sh;
    relu_en = relu;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    loads++;
  endtask

  task automatic drain_wait(input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!mif.m_valid && sb.size() == 0) break;
    end
    chk(name, 32'(sb.size() == 0 && !mif.m_valid), 32'd1);
  endtask

  initial begin
    int b0, a0;
    rst         = 1'b1;
    load        = 1'b0;
    din         = '0;
    shift       = '0;
    relu_en     = 1'b0;
    mif.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   32'(mif.m_valid), 32'd0);
    chk("rst_ready",   32'(ready_in),    32'd1);
    chk("rst_acc_clr", 32'(acc_clr),     32'd0);
    chk("rst_overrun", 32'(overrun),     32'd0);
    chk("rst_lane",    32'(mif.m_lane),  32'd0);
    chk("rst_data",    32'(mif.m_data),  32'd0);
    chk("rst_last",    32'(mif.m_last),  32'd0);
    chk("rst_sat",     32'(mif.sat),     32'd0);
    rst = 1'b0;

    // 1: basic drain, shift 0, saturation both ways
    mif.m_ready = 1'b1;
    vin = '{5, -3, 100, -200, 0, 127, 128};
    ed  = '{5, -3, 100, -128, 0, 127, 127};
    es  = '{0, 0, 0, 1, 0, 0, 1};
    b0 = beats; a0 = acc_cnt;
    load_vec(5'd0, 1'b0);
    chk("t1_latency_valid", 32'(mif.m_valid), 32'd1);
    chk("t1_latency_lane",  32'(mif.m_lane),  32'd0);
    chk("t1_acc_clr_pulse", 32'(acc_clr),     32'd1);
    @(posedge clk);
    #1;
    chk("t1_acc_clr_drop",  32'(acc_clr),     32'd0);
    drain_wait("t1_drain");
    chk("t1_beats",   32'(beats - b0),   32'd7);
    chk("t1_acc_cnt", 32'(acc_cnt - a0), 32'd1);

    // 2a: rounding shift 4
    vin = '{384, 0, -8, 7, 8, -9, 2047};
    ed  = '{24, 0, 0, 0, 1, -1, 127};
    es  = '{0, 0, 0, 0, 0, 0, 1};
    load_vec(5'd4, 1'b0);
    drain_wait("t2a_drain");

    // 2b: rounding shift 1, negative floor and saturation edges
    vin = '{-25, -24, 3, 255, 256, -256, -257};
    ed  = '{-12, -12, 2, 127, 127, -128, -128};
    es  = '{0, 0, 0, 1, 1, 0, 0};
    load_vec(5'd1, 1'b0);
    drain_wait("t2b_drain");

    // 3: ReLU with shift 31, widened rounding sum
    vin = '{-1000, 32'h7FFF_FFFF, -1, 32'h8000_0000, 32'h4000_0000, 32'h3FFF_FFFF, 5};
    ed  = '{0, 1, 0, 0, 1, 0, 0};
    es  = '{0, 0, 0, 0, 0, 0, 0};
    load_vec(5'd31, 1'b1);
    drain_wait("t3_drain");

    // 4: stalled drain, m_ready pattern 1,0,0 repeating
    mif.m_ready = 1'b0;
    vin = '{-5, 50, 300, -1, 1, -128, 127};
    ed  = '{0, 50, 127, 0, 1, 0, 127};
    es  = '{0, 0, 1, 0, 0, 0, 0};
    b0 = beats;
    load_vec(5'd0, 1'b1);
    for (int k = 0; k < 60; k++) begin
      mif.m_ready = (k % 3 == 0);
      @(posedge clk);
      #1;
      if (beats - b0 >= 7) break;
    end
    mif.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_beats", 32'(beats - b0), 32'd7);
    chk("t4_idle",  32'(mif.m_valid), 32'd0);

    // 5: back-to-back load on the last beat, then an overrun at lane 3
    vin = '{10, -10, 6, -6, 509, -511, -600};
    ed  = '{3, -2, 2, -1, 127, -128, -128};
    es  = '{0, 0, 0, 0, 0, 0, 1};
    load_vec(5'd2, 1'b0);
    vin = '{32'h8000_0000, 32'h7FFF_FFFF, 0, -1, 1, 32'hC000_0000, 32'h4000_0000};
    ed  = '{-1, 1, 0, 0, 0, 0, 1};
    es  = '{0, 0, 0, 0, 0, 0, 0};
    load_vec(5'd31, 1'b0);
    chk("t5_b2b_valid", 32'(mif.m_valid), 32'd1);
    chk("t5_b2b_lane",  32'(mif.m_lane),  32'd0);
    chk("t5_b2b_clr",   32'(acc_clr),     32'd1);
    chk("t5_no_overrun", 32'(overrun),    32'd0);
    for (int n = 0; n < 20; n++) begin
      if (mif.m_lane == 3'd3) break;
      @(posedge clk);
      #1;
    end
    din  = '1;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("t5_overrun_set", 32'(overrun), 32'd1);
    drain_wait("t5_drain");
    chk("t5_overrun_sticky", 32'(overrun), 32'd1);

    // 6: reset mid-drain at lane 4, then a fresh vector
    vin = '{1, 2, 3, 4, 5, 6, 7};
    ed  = '{1, 2, 3, 4, 5, 6, 7};
    es  = '{0, 0, 0, 0, 0, 0, 0};
    b0 = beats;
    load_vec(5'd0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      if (mif.m_lane == 3'd4) break;
      @(posedge clk);
      #1;
    end
    rst         = 1'b1;
    mif.m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("t6_beats_before_rst", 32'(beats - b0), 32'd4);
    chk("t6_valid",   32'(mif.m_valid), 32'd0);
    chk("t6_ready",   32'(ready_in),    32'd1);
    chk("t6_overrun", 32'(overrun),     32'd0);
    chk("t6_lane",    32'(mif.m_lane),  32'd0);
    mif.m_ready = 1'b1;
    vin = '{-1, -2, -3, -4, -5, -6, -7};
    ed  = '{-1, -2, -3, -4, -5, -6, -7};
    load_vec(5'd0, 1'b0);
    drain_wait("t6_drain");

    chk("acc_clr_total", 32'(acc_cnt), 32'(loads));
    chk("sb_empty",      32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
